st7701_spi9_rx: RTL and testbench
=================================

Name: st7701_spi9_rx

Overview:
Receive end of the ST7701 3-wire 9-bit SPI link. Oversamples cs/sclk/sdi in the system clock domain and assembles 9-bit words (D/C bit + 8 data bits). Tags each word with its owning command byte and parameter index, then buffers it in a show-ahead FIFO with a valid/ready interface. Used as a panel-side model in simulation and as an on-chip monitor that checks the init sequence the panel driver emits.

Parameters:
FIFO_DEPTH, 4, number of buffered words; power of two, 2..16.
SYNC_STAGES, 2, synchronizer flops on cs/sclk/sdi; minimum 2.

Ports:
clk  in  1  system clock; f_clk >= 8 x f_sclk.
rst  in  1  synchronous reset, active-high.
spi_cs  in  1  chip select, active-low, asynchronous to clk.
spi_sclk  in  1  serial clock, idles low; transmitter changes data on falling edge.
spi_sdi  in  1  serial data, MSB (D/C) first.
word_valid  out  1  FIFO head valid.
word_ready  in  1  consumer accepts head when word_valid & word_ready.
word_dc  out  1  0 = command, 1 = parameter.
word_data  out  8  data byte.
word_cmd  out  8  command byte owning this word; equals word_data for command words.
word_pidx  out  8  parameter index since last command (0 for the command word; first parameter = 0); saturates at 255.
frame_err  out  1  sticky: cs rose with partial word.
overflow  out  1  sticky: word dropped because FIFO full.
err_clr  in  1  one-cycle pulse clears frame_err and overflow.
cmd_count  out  16  command words received (feature-dependent).
param_count  out  16  parameter words received (feature-dependent).

Behaviour:
- Reset values: word_valid=0, word_dc=0, word_data=0, word_cmd=0, word_pidx=0, frame_err=0, overflow=0, counts=0. FIFO empty, bit_cnt=0, last_cmd=0x00, pidx=0. Sync flops reset to idle: cs=1, sclk=0, sdi=0.
- Reset mid-word discards the partial word. Reception restarts only after the synced cs is seen high or the next sclk rising edge while cs is low; bits before reset are never merged.
- Edge detect: sclk_rise = synced sclk & ~previous synced sclk. Sampling uses synced sdi on that cycle.
- Receive FSM:
  - IDLE: cs high. bit_cnt held at 0. Synced cs falling -> SHIFT.
  - SHIFT: on each sclk_rise, shreg <= {shreg[7:0], sdi} and bit_cnt++. When the 9th bit is sampled: bit_cnt <= 0, push word, stay in SHIFT. cs may remain low across consecutive words; word boundaries come only from counting.
  - Synced cs rising -> IDLE. If bit_cnt != 0, set frame_err and discard the partial word.
- Tagging at push:
  - dc=0: last_cmd <= byte, pidx <= 0; word tagged cmd=byte, pidx=0.
  - dc=1: tagged cmd=last_cmd, pidx=current pidx; then pidx++ with saturation at 255.
  - A parameter before any command is tagged cmd=0x00.
- FIFO:
  - Show-ahead; outputs come straight from the head entry.
  - A push at cycle N into an empty FIFO gives word_valid=1 at N+1.
  - Push while full with no pop in the same cycle: word dropped, overflow set; tagging state still updates.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
- err_clr has priority below a same-cycle set: the flag remains 1.

Optional Feature:
SPI9_RX_STATS_EN
- Defined: cmd_count and param_count increment on every completed word, including words dropped by overflow. Both saturate at 0xFFFF and clear only on rst.
- Undefined: both outputs are tied to 0 and no counter logic is generated.

Test Plan:
- Send 0x11 (dc=0), then cs high, sclk=clk/8, word_ready=1 -> one word out: dc=0, data=0x11, cmd=0x11, pidx=0; frame_err=0.
- cs held low; send 0xC0, 0x13B, 0x100 -> words in order: (0,C0,C0,0), (1,3B,C0,0), (1,00,C0,1).
- Hold word_ready=0; send FIFO_DEPTH+1 words -> first 4 buffered and intact, 5th dropped, overflow=1. Then release ready -> 4 words drain in order; err_clr -> overflow=0.
- Send 5 bits, then raise cs -> frame_err=1, no word pushed. Next full word 0x29 is received correctly.
- Assert rst after 4 bits of a word, release, then send 0x3A, 0x150 -> only these two words appear, tagged (0,3A,3A,0) and (1,50,3A,0).
- With SPI9_RX_STATS_EN defined: replay the full 190-word panel init stream -> cmd_count=27, param_count=163, last word (1,50,3A,0). With the macro undefined, both counts read 0.

Source files
------------

// File: rtl/st7701_spi9_rx_if.sv
// Word stream from the ST7701 9-bit SPI receiver: show-ahead head entry plus valid/ready.
// master = receiver (drives the word), slave = consumer (drives ready).
interface st7701_spi9_rx_if;
    logic       word_valid;
    logic       word_ready;
    logic       word_dc;
    logic [7:0] word_data;
    logic [7:0] word_cmd;
    logic [7:0] word_pidx;

    modport master (
        output word_valid,
        output word_dc,
        output word_data,
        output word_cmd,
        output word_pidx,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_dc,
        input  word_data,
        input  word_cmd,
        input  word_pidx,
        output word_ready
    );
endinterface

// File: rtl/st7701_spi9_rx.sv
// ST7701 3-wire 9-bit SPI receiver: oversampled capture, command/parameter tagging, show-ahead FIFO.
// Optional macro SPI9_RX_STATS_EN enables saturating command/parameter word counters.
module st7701_spi9_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_cs,
    input  logic                   spi_sclk,
    input  logic                   spi_sdi,
    st7701_spi9_rx_if.master       word,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   err_clr,
    output logic [15:0]            cmd_count,
    output logic [15:0]            param_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic [7:0] cmd;
        logic [7:0] pidx;
    } entry_t;

    // ---------------- input synchronizers ----------------
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic cs_s, sdi_s, cs_fall, sclk_rise;

    always_comb begin
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        sdi_s     = sdi_sync_q[SYNC_STAGES-1];
        cs_fall   = cs_prev_q & ~cs_s;
        sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    end

    // ---------------- receive FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push;
    logic       frame_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cs_s) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    frame_set = (bit_cnt_q != 4'd0);
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[6:0], sdi_s};
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        push      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The 9th bit is still in sdi_s on the push cycle; shreg_q holds the first eight.
    logic       push_dc;
    logic [7:0] push_byte;

    always_comb begin
        push_dc   = shreg_q[7];
        push_byte = {shreg_q[6:0], sdi_s};
    end

    // ---------------- tagging ----------------
    logic [7:0] last_cmd_q, last_cmd_d;
    logic [7:0] pidx_q, pidx_d;
    entry_t     push_entry;

    always_comb begin
        last_cmd_d      = last_cmd_q;
        pidx_d          = pidx_q;
        push_entry.dc   = push_dc;
        push_entry.data = push_byte;
        push_entry.cmd  = push_dc ? last_cmd_q : push_byte;
        push_entry.pidx = push_dc ? pidx_q : 8'h00;
        if (push) begin
            if (!push_dc) begin
                last_cmd_d = push_byte;
                pidx_d     = 8'h00;
            end else if (pidx_q != 8'hFF) begin
                pidx_d = pidx_q + 8'h01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cmd_q <= '0;
            pidx_q     <= '0;
        end else begin
            last_cmd_q <= last_cmd_d;
            pidx_q     <= pidx_d;
        end
    end

    // ---------------- show-ahead FIFO ----------------
    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            pop, full, wr_en, ovf_set;
    entry_t          head;

    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = (count_q != '0) & word.word_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en    = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head            = mem_q[rd_ptr_q];
        word.word_valid = (count_q != '0);
        word.word_dc    = head.dc;
        word.word_data  = head.data;
        word.word_cmd   = head.cmd;
        word.word_pidx  = head.pidx;
    end

    // ---------------- sticky error flags ----------------
    logic frame_err_q, overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
            overflow_q  <= ovf_set | (overflow_q & ~err_clr);
        end
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    // ---------------- optional statistics ----------------
`ifdef SPI9_RX_STATS_EN
    logic [15:0] cmd_cnt_q, cmd_cnt_d;
    logic [15:0] par_cnt_q, par_cnt_d;

    // Counted on every completed word, including ones the FIFO drops.
    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        par_cnt_d = par_cnt_q;
        if (push && !push_dc && cmd_cnt_q != 16'hFFFF) begin
            cmd_cnt_d = cmd_cnt_q + 16'd1;
        end
        if (push && push_dc && par_cnt_q != 16'hFFFF) begin
            par_cnt_d = par_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt_q <= '0;
            par_cnt_q <= '0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            par_cnt_q <= par_cnt_d;
        end
    end

    assign cmd_count   = cmd_cnt_q;
    assign param_count = par_cnt_q;
`else
    assign cmd_count   = '0;
    assign param_count = '0;
`endif

endmodule

// File: tb/tb_st7701_spi9_rx.sv
// Directed bench for st7701_spi9_rx: bit-banged 9-bit SPI words, tag model and scoreboard queue.
module tb_st7701_spi9_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs;
    logic        spi_sclk;
    logic        spi_sdi;
    logic        err_clr;
    logic        frame_err;
    logic        overflow;
    logic [15:0] cmd_count;
    logic [15:0] param_count;

    st7701_spi9_rx_if w_if ();

    st7701_spi9_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_sdi     (spi_sdi),
        .word        (w_if),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .err_clr     (err_clr),
        .cmd_count   (cmd_count),
        .param_count (param_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  m_cmd;
    logic [7:0]  m_pidx;
    logic [15:0] n_cmd;
    logic [15:0] n_par;
    logic [24:0] last_obs = '0;
    logic [24:0] obs;
    logic [24:0] exp_word;
    logic [24:0] final_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cmd  = 8'h00;
        m_pidx = 8'h00;
        n_cmd  = 16'd0;
        n_par  = 16'd0;
    endtask

    task automatic send_bits(input logic [8:0] w, input int nbits);
        for (int i = 8; i > 8 - nbits; i--) begin
            spi_sdi = w[i];
            wait_clk(4);
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [8:0] w, input bit stored);
        logic [24:0] e;
        if (!w[8]) begin
            e      = {1'b0, w[7:0], w[7:0], 8'h00};
            m_cmd  = w[7:0];
            m_pidx = 8'h00;
            if (n_cmd != 16'hFFFF) n_cmd++;
        end else begin
            e = {1'b1, w[7:0], m_cmd, m_pidx};
            if (m_pidx != 8'hFF) m_pidx++;
            if (n_par != 16'hFFFF) n_par++;
        end
        if (stored) exp_q.push_back(e);
        send_bits(w, 9);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(4);
        spi_cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || w_if.word_valid) && k < 400) begin
            wait_clk(1);
            k++;
        end
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_valid"}, {31'd0, w_if.word_valid}, 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    // Scoreboard: a word is consumed on the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (!rst && w_if.word_valid && w_if.word_ready) begin
            obs = {w_if.word_dc, w_if.word_data, w_if.word_cmd, w_if.word_pidx};
            if (exp_q.size() == 0) begin
                check("spurious_word", {7'd0, obs}, 0);
            end else begin
                exp_word = exp_q.pop_front();
                check("word", {7'd0, obs}, {7'd0, exp_word});
                last_obs = obs;
            end
        end
    end

    initial begin
        rst             = 1'b1;
        spi_cs          = 1'b1;
        spi_sclk        = 1'b0;
        spi_sdi         = 1'b0;
        err_clr         = 1'b0;
        w_if.word_ready = 1'b0;
        model_reset();
        wait_clk(4);

        check("rst_valid", {31'd0, w_if.word_valid}, 0);
        check("rst_dc", {31'd0, w_if.word_dc}, 0);
        check("rst_data", {24'd0, w_if.word_data}, 0);
        check("rst_cmd", {24'd0, w_if.word_cmd}, 0);
        check("rst_pidx", {24'd0, w_if.word_pidx}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_cmd_count", {16'd0, cmd_count}, 0);
        check("rst_param_count", {16'd0, param_count}, 0);

        rst = 1'b0;
        w_if.word_ready = 1'b1;
        wait_clk(2);

        // single command word in its own frame
        cs_low();
        send_word(9'h011, 1'b1);
        cs_high();
        drain("single");
        check("single_frame_err", {31'd0, frame_err}, 0);

        // back-to-back words under one cs
        cs_low();
        send_word(9'h0C0, 1'b1);
        send_word(9'h13B, 1'b1);
        send_word(9'h100, 1'b1);
        cs_high();
        drain("burst");

        // overflow: stalled consumer, one word more than the FIFO holds
        w_if.word_ready = 1'b0;
        cs_low();
        send_word(9'h0B5, 1'b1);
        for (int i = 1; i < 5; i++) begin
            send_word({1'b1, 8'(i * 8'h11)}, i < 4);
        end
        cs_high();
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_valid", {31'd0, w_if.word_valid}, 1);
        check("ovf_head", {24'd0, w_if.word_data}, 32'hB5);
        w_if.word_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", {31'd0, overflow}, 1);
        pulse_err_clr();
        check("ovf_cleared", {31'd0, overflow}, 0);

        // partial word then cs rise
        cs_low();
        send_bits(9'h1FF, 5);
        cs_high();
        check("frame_err_set", {31'd0, frame_err}, 1);
        check("frame_no_word", {31'd0, w_if.word_valid}, 0);
        cs_low();
        send_word(9'h029, 1'b1);
        cs_high();
        drain("after_frame");
        check("frame_err_sticky", {31'd0, frame_err}, 1);
        pulse_err_clr();
        check("frame_err_cleared", {31'd0, frame_err}, 0);

        // reset in the middle of a word
        cs_low();
        send_bits(9'h0AA, 4);
        rst = 1'b1;
        wait_clk(3);
        model_reset();
        rst    = 1'b0;
        spi_cs = 1'b1;
        wait_clk(8);
        check("midrst_frame_err", {31'd0, frame_err}, 0);
        check("midrst_valid", {31'd0, w_if.word_valid}, 0);
        cs_low();
        send_word(9'h03A, 1'b1);
        send_word(9'h150, 1'b1);
        cs_high();
        drain("midrst");
`ifdef SPI9_RX_STATS_EN
        check("midrst_cmd_count", {16'd0, cmd_count}, {16'd0, n_cmd});
        check("midrst_param_count", {16'd0, param_count}, {16'd0, n_par});
`else
        check("midrst_cmd_count", {16'd0, cmd_count}, 0);
        check("midrst_param_count", {16'd0, param_count}, 0);
`endif

        // 190-word init stream: 27 commands, 163 parameters, ending with 3A/50
        rst = 1'b1;
        wait_clk(3);
        model_reset();
        rst = 1'b0;
        wait_clk(2);
        cs_low();
        for (int c = 0; c < 26; c++) begin
            send_word({1'b0, 8'(8'hB0 + c)}, 1'b1);
            for (int p = 0; p < ((c < 6) ? 7 : 6); p++) begin
                send_word({1'b1, 8'(c * 16 + p)}, 1'b1);
            end
        end
        send_word(9'h03A, 1'b1);
        send_word(9'h150, 1'b1);
        cs_high();
        drain("stream");
        final_word = {1'b1, 8'h50, 8'h3A, 8'h00};
        check("stream_last_word", {7'd0, last_obs}, {7'd0, final_word});
        check("stream_frame_err", {31'd0, frame_err}, 0);
`ifdef SPI9_RX_STATS_EN
        check("stream_cmd_count", {16'd0, cmd_count}, 32'd27);
        check("stream_param_count", {16'd0, param_count}, 32'd163);
`else
        check("stream_cmd_count", {16'd0, cmd_count}, 0);
        check("stream_param_count", {16'd0, param_count}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
